// File: rtl/cache_fill_fsm.sv
// rtl/cache_fill_fsm.sv - cache miss fill controller: eight pipelined word reads then one tag write
module cache_fill_fsm #(
    parameter int WORDS_PER_BLOCK = 8,
    parameter int ADDR_WIDTH      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  miss_detected,
    input  logic [ADDR_WIDTH-1:0] miss_address,
    input  logic                  memory_data_valid,
    output logic                  fsm_busy,
    output logic                  write_data_array,
    output logic                  write_tag_array,
    output logic [ADDR_WIDTH-1:0] memory_address,
    output logic                  mem_read
);
    localparam int CNT_W = $clog2(WORDS_PER_BLOCK);
    localparam int OFF_W = CNT_W + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WORDS_PER_BLOCK - 1);

    typedef enum logic [1:0] {IDLE, FILL, TAG} state_t;

    state_t                      state;
    logic [CNT_W-1:0]            req_cnt;
    logic [CNT_W-1:0]            rcv_cnt;
    logic [ADDR_WIDTH-1:OFF_W]   blk;

    // Byte/word offset bits of the miss are regenerated from the counters.
    logic unused_low;
    assign unused_low = &{1'b0, miss_address[OFF_W-1:0]};

    assign write_data_array = (state == FILL) && memory_data_valid;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state           <= IDLE;
            req_cnt         <= '0;
            rcv_cnt         <= '0;
            blk             <= '0;
            fsm_busy        <= 1'b0;
            write_tag_array <= 1'b0;
            mem_read        <= 1'b0;
            memory_address  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    write_tag_array <= 1'b0;
                    if (miss_detected) begin
                        blk            <= miss_address[ADDR_WIDTH-1:OFF_W];
                        req_cnt        <= '0;
                        rcv_cnt        <= '0;
                        state          <= FILL;
                        fsm_busy       <= 1'b1;
                        mem_read       <= 1'b1;
                        memory_address <= {miss_address[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
                    end else begin
                        fsm_busy       <= 1'b0;
                        mem_read       <= 1'b0;
                        memory_address <= {blk, {OFF_W{1'b0}}};
                    end
                end
                FILL: begin
                    // mem_read doubles as the "requests still to issue" flag.
                    if (mem_read) begin
                        req_cnt <= req_cnt + CNT_W'(1);
                        if (req_cnt == LAST) begin
                            mem_read <= 1'b0;
                        end else begin
                            memory_address <= {blk, req_cnt + CNT_W'(1), 1'b0};
                        end
                    end
                    if (memory_data_valid) begin
                        rcv_cnt <= rcv_cnt + CNT_W'(1);
                        if (rcv_cnt == LAST) begin
                            state           <= TAG;
                            write_tag_array <= 1'b1;
                            mem_read        <= 1'b0;
                        end
                    end
                end
                TAG: begin
                    state           <= IDLE;
                    write_tag_array <= 1'b0;
                    fsm_busy        <= 1'b0;
                    mem_read        <= 1'b0;
                    memory_address  <= {blk, {OFF_W{1'b0}}};
                end
                default: begin
                    state           <= IDLE;
                    fsm_busy        <= 1'b0;
                    write_tag_array <= 1'b0;
                    mem_read        <= 1'b0;
                end
            endcase
        end
    end
endmodule
